cdb_arbiter: RTL

//   Common-data-bus arbiter for the Tomasulo core. Shares the single result broadcast bus between
//   NUM_REQ functional units (adder, multiplier, load, branch) using round-robin arbitration.
//   The broadcast tag/data pair is consumed by the register status table, the reservation stations
//   and the ROB to resolve pending q1/q2 tags. One broadcast per cycle, registered output.

---
 rtl/cdb_arbiter.sv | 94 +++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: round-robin grant among functional units, one registered
// tag/data broadcast per cycle, with stall/flush handling and a sticky invalid-tag flag.
module cdb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2,
  parameter int TAG_W   = 6,
  parameter int DATA_W  = 32,
  parameter logic [TAG_W-1:0] INVALID = 6'b010000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      cdb_stall,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [IDX_W-1:0]          cdb_src,
  output logic                      bad_tag,
  output logic [15:0]               bcast_count
);

  logic [IDX_W-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] elig_p0;
  logic               bad_any_p0;
  logic               gnt_vld_p0;
  logic [IDX_W-1:0]   gnt_idx_p0;
  logic [TAG_W-1:0]   gnt_tag_p0;
  logic [DATA_W-1:0]  gnt_data_p0;
  logic [IDX_W-1:0]   nxt_ptr_p0;

  // Stage p0: eligibility, round-robin scan starting at rr_ptr, one-hot grant
  always_comb begin
    bad_any_p0 = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig_p0[i] = req_valid[i] && (req_tag[i*TAG_W +: TAG_W] < INVALID);
      bad_any_p0 = bad_any_p0 | (req_valid[i] & ~elig_p0[i]);
    end
  end

  always_comb begin
    int idx;
    gnt_vld_p0  = 1'b0;
    gnt_idx_p0  = '0;
    gnt_tag_p0  = INVALID;
    gnt_data_p0 = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_vld_p0 && elig_p0[idx]) begin
        gnt_vld_p0  = 1'b1;
        gnt_idx_p0  = IDX_W'(idx);
        gnt_tag_p0  = req_tag[idx*TAG_W +: TAG_W];
        gnt_data_p0 = req_data[idx*DATA_W +: DATA_W];
      end
    end
    // Back-pressure, flush and reset all suppress the grant so nothing transfers
    if (flush || cdb_stall || !rst_n) gnt_vld_p0 = 1'b0;
    req_ready = '0;
    if (gnt_vld_p0) req_ready[gnt_idx_p0] = 1'b1;
    nxt_ptr_p0 = (gnt_idx_p0 == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx_p0 + 1'b1;
  end

  // Stage p1: registered broadcast, pointer advance and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid   <= 1'b0;
      cdb_tag     <= INVALID;
      cdb_data    <= '0;
      cdb_src     <= '0;
      rr_ptr      <= '0;
      bad_tag     <= 1'b0;
      bcast_count <= '0;
    end else begin
      if (bad_any_p0) bad_tag <= 1'b1;
      if (gnt_vld_p0) begin
        cdb_valid   <= 1'b1;
        cdb_tag     <= gnt_tag_p0;
        cdb_data    <= gnt_data_p0;
        cdb_src     <= gnt_idx_p0;
        rr_ptr      <= nxt_ptr_p0;
        bcast_count <= bcast_count + 16'd1;
      end else begin
        cdb_valid <= 1'b0;
        cdb_tag   <= INVALID;
        if (flush) rr_ptr <= '0;
      end
    end
  end

endmodule
